// File: rtl/apb_pkg.sv
// Shared types for the queued APB4 requester: FSM states, queued command and response records.
// Record fields are sized for the widest APB4 bus (32-bit address/data); narrower instances leave upper bits unused.
package apb_pkg;

  localparam int APB_ADDR_MAX = 32;
  localparam int APB_DATA_MAX = 32;
  localparam int APB_STRB_MAX = APB_DATA_MAX / 8;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2
  } state_t;

  typedef struct packed {
    logic [APB_DATA_MAX-1:0] rdata;
    logic                    slverr;
    logic                    timeout;
  } rsp_t;

  typedef struct packed {
    logic [APB_ADDR_MAX-1:0] addr;
    logic                    write;
    logic [APB_DATA_MAX-1:0] wdata;
    logic [APB_STRB_MAX-1:0] strb;
    logic [2:0]              prot;
  } cmd_t;

endpackage

// File: rtl/sync_fifo.sv
// Synchronous first-word-fall-through FIFO; head is valid whenever empty is low.
// Push is ignored when full, pop is ignored when empty; simultaneous push and pop leave level unchanged.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push,
  input  logic [WIDTH-1:0]         data_in,
  input  logic                     pop,
  output logic [WIDTH-1:0]         head,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign full    = (level == LW'(DEPTH));
  assign empty   = (level == '0);
  assign head    = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      level <= level + LW'(do_push) - LW'(do_pop);
    end
  end

  // Storage needs no reset: entries are only read after being written.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= data_in;
  end

endmodule

// File: rtl/apb4_master_q.sv
// Queued APB4 requester: commands wait in a FWFT queue, run back-to-back on APB, return as one-cycle response pulses.
// Zero-wait latency 3 cycles from acceptance, +1 per wait state; o_cmd_ready = !full, responses cannot be stalled.
module apb4_master_q
  import apb_pkg::*;
#(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int DEPTH   = 4,
  parameter int TIMEOUT = 16
) (
  input  logic                    i_clk,
  input  logic                    i_reset,
  input  logic                    i_cmd_valid,
  output logic                    o_cmd_ready,
  input  logic [ADDR_W-1:0]       i_cmd_addr,
  input  logic                    i_cmd_write,
  input  logic [DATA_W-1:0]       i_cmd_wdata,
  input  logic [DATA_W/8-1:0]     i_cmd_strb,
  input  logic [2:0]              i_cmd_prot,
  output logic                    o_rsp_valid,
  output logic [DATA_W-1:0]       o_rsp_rdata,
  output logic                    o_rsp_slverr,
  output logic                    o_rsp_timeout,
  output logic [$clog2(DEPTH):0]  o_level,
  output logic                    o_busy,
  output logic [ADDR_W-1:0]       PADDR,
  output logic                    PWRITE,
  output logic [DATA_W-1:0]       PWDATA,
  output logic [DATA_W/8-1:0]     PSTRB,
  output logic [2:0]              PPROT,
  output logic                    PSELx,
  output logic                    PENABLE,
  input  logic [DATA_W-1:0]       PRDATA,
  input  logic                    PREADY,
  input  logic                    PSLVERR
);

  localparam int STRB_W = DATA_W / 8;
  localparam int WD_W   = $clog2(TIMEOUT + 2);

  cmd_t              cmd_in;
  cmd_t              head;
  logic              fifo_full;
  logic              fifo_empty;
  logic              pop;
  state_t            state;
  logic [WD_W-1:0]   wd_cnt;
  logic [WD_W-1:0]   wd_next;
  logic              timeout_hit;
  logic              rsp_valid;
  rsp_t              rsp;
  logic [ADDR_W-1:0] head_addr;
  logic [DATA_W-1:0] head_wdata;
  logic [STRB_W-1:0] head_strb;

  always_comb begin
    cmd_in       = '0;
    cmd_in.addr  = APB_ADDR_MAX'(i_cmd_addr);
    cmd_in.write = i_cmd_write;
    cmd_in.wdata = APB_DATA_MAX'(i_cmd_wdata);
    cmd_in.strb  = APB_STRB_MAX'(i_cmd_strb);
    cmd_in.prot  = i_cmd_prot;
  end

  // The head is loaded from IDLE or straight out of a completing ACCESS, never after an abort.
  assign pop = !fifo_empty && ((state == IDLE) || ((state == ACCESS) && PREADY));

  sync_fifo #(
    .WIDTH ($bits(cmd_t)),
    .DEPTH (DEPTH)
  ) u_cmd_q (
    .clk     (i_clk),
    .reset   (i_reset),
    .push    (i_cmd_valid),
    .data_in (cmd_in),
    .pop     (pop),
    .head    (head),
    .full    (fifo_full),
    .empty   (fifo_empty),
    .level   (o_level)
  );

  assign head_addr   = head.addr[ADDR_W-1:0];
  assign head_wdata  = head.wdata[DATA_W-1:0];
  assign head_strb   = head.write ? head.strb[STRB_W-1:0] : '0;
  assign wd_next     = wd_cnt + WD_W'(1);
  assign timeout_hit = (TIMEOUT != 0) && (wd_next == WD_W'(TIMEOUT));

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state     <= IDLE;
      PSELx     <= 1'b0;
      PENABLE   <= 1'b0;
      PADDR     <= '0;
      PWRITE    <= 1'b0;
      PWDATA    <= '0;
      PSTRB     <= '0;
      PPROT     <= '0;
      wd_cnt    <= '0;
      rsp_valid <= 1'b0;
      rsp       <= '0;
    end else begin
      rsp_valid <= 1'b0;
      rsp       <= '0;
      case (state)
        IDLE: begin
          if (!fifo_empty) begin
            PADDR   <= head_addr;
            PWRITE  <= head.write;
            PWDATA  <= head_wdata;
            PSTRB   <= head_strb;
            PPROT   <= head.prot;
            PSELx   <= 1'b1;
            PENABLE <= 1'b0;
            state   <= SETUP;
          end
        end
        SETUP: begin
          PENABLE <= 1'b1;
          wd_cnt  <= '0;
          state   <= ACCESS;
        end
        ACCESS: begin
          // A ready slave wins over the watchdog on the boundary cycle.
          if (PREADY) begin
            rsp_valid  <= 1'b1;
            rsp.rdata  <= PWRITE ? '0 : APB_DATA_MAX'(PRDATA);
            rsp.slverr <= PSLVERR;
            PENABLE    <= 1'b0;
            if (!fifo_empty) begin
              PADDR  <= head_addr;
              PWRITE <= head.write;
              PWDATA <= head_wdata;
              PSTRB  <= head_strb;
              PPROT  <= head.prot;
              state  <= SETUP;
            end else begin
              PSELx <= 1'b0;
              state <= IDLE;
            end
          end else begin
            if (TIMEOUT != 0) wd_cnt <= wd_next;
            if (timeout_hit) begin
              rsp_valid   <= 1'b1;
              rsp.slverr  <= 1'b1;
              rsp.timeout <= 1'b1;
              PSELx       <= 1'b0;
              PENABLE     <= 1'b0;
              state       <= IDLE;
            end
          end
        end
        default: begin
          PSELx   <= 1'b0;
          PENABLE <= 1'b0;
          state   <= IDLE;
        end
      endcase
    end
  end

  assign o_cmd_ready   = !fifo_full;
  assign o_busy        = (state != IDLE);
  assign o_rsp_valid   = rsp_valid;
  assign o_rsp_rdata   = rsp.rdata[DATA_W-1:0];
  assign o_rsp_slverr  = rsp.slverr;
  assign o_rsp_timeout = rsp.timeout;

endmodule

// File: doc/apb4_master_q.md
Name: apb4_master_q

Overview:
- Parametrised APB4 requester: generalises the single-shot APB master to configurable address/data width.
- Adds a command queue, back-to-back transfers, PSTRB/PPROT, and a wait-state timeout watchdog.
- Sits between internal command producers (CPU bridge, DMA) and the APB interconnect.
- Completed transfers return as one-cycle response pulses.

Parameters:
- ADDR_W, 32, APB address width.
- DATA_W, 32, APB data width; must be 8, 16 or 32.
- DEPTH, 4, command FIFO entries; power of two, ≥2.
- TIMEOUT, 16, max ACCESS-phase cycles without PREADY before abort; 0 disables the watchdog.

Ports:
- i_clk  in  1  clock; all logic on rising edge.
- i_reset  in  1  synchronous, active-high reset.
- i_cmd_valid  in  1  command offered.
- o_cmd_ready  out  1  queue can accept; equals !full.
- i_cmd_addr  in  ADDR_W  transfer address.
- i_cmd_write  in  1  1=write, 0=read.
- i_cmd_wdata  in  DATA_W  write data.
- i_cmd_strb  in  DATA_W/8  byte strobes; ignored for reads.
- i_cmd_prot  in  3  PPROT value.
- o_rsp_valid  out  1  one-cycle completion pulse; no back-pressure.
- o_rsp_rdata  out  DATA_W  PRDATA captured for reads, 0 for writes.
- o_rsp_slverr  out  1  PSLVERR at completion, or 1 on timeout.
- o_rsp_timeout  out  1  transfer aborted by the watchdog.
- o_level  out  $clog2(DEPTH)+1  queued command count.
- o_busy  out  1  FSM not IDLE.
- PADDR  out  ADDR_W.
- PWRITE  out  1.
- PWDATA  out  DATA_W.
- PSTRB  out  DATA_W/8.
- PPROT  out  3.
- PSELx  out  1.
- PENABLE  out  1.
- PRDATA  in  DATA_W.
- PREADY  in  1.
- PSLVERR  in  1.

Behaviour:
- Reset: every output is 0 except o_cmd_ready, which is 1. FIFO is flushed, FSM goes to IDLE, watchdog counter is cleared.
- Reset mid-transfer: PSELx/PENABLE drop on the next edge. No response is issued for the in-flight command or any queued command.
- Push: occurs on i_cmd_valid && o_cmd_ready. Push is blocked when full. A push and a pop in the same cycle are both honoured, so o_level is unchanged.
- FSM states:
  - IDLE:
    - FIFO not empty → pop the head, register PADDR/PWRITE/PWDATA/PSTRB/PPROT, PSELx=1, PENABLE=0, go to SETUP.
    - A command pushed at edge N is visible to the FSM after edge N; PSELx rises at edge N+1.
  - SETUP: PENABLE=1, clear the watchdog counter, go to ACCESS.
  - ACCESS with PREADY=1:
    - Pulse o_rsp_valid on the next cycle with rdata (read) or 0 (write), slverr=PSLVERR, timeout=0.
    - FIFO not empty → pop and load the next command, keep PSELx=1, PENABLE=0, go to SETUP (back-to-back, no idle cycle).
    - FIFO empty → PSELx=0, PENABLE=0, go to IDLE.
  - ACCESS with PREADY=0: increment the watchdog counter.
    - If TIMEOUT≠0 and the counter reaches TIMEOUT: abort. PSELx=0, PENABLE=0, response slverr=1, timeout=1, rdata=0, go to IDLE.
    - An aborted transfer never proceeds directly to SETUP.
- Latency: with zero wait states, o_rsp_valid is high 3 cycles after command acceptance.
  - Each PREADY=0 cycle adds 1.
  - Back-to-back transfer throughput is 1 per 2 cycles.
- PSTRB: driven to 0 for reads, as APB4 requires.
- APB stability: PADDR, PWRITE, PWDATA, PSTRB and PPROT are stable from SETUP until PREADY completion. They hold their last values in IDLE.
- Exact-timeout boundary: PREADY=1 in the same cycle the counter would reach TIMEOUT counts as a normal completion, not a timeout.
- An unknown or illegal state code returns to IDLE.

Decomposition:
- Package apb_pkg:
  - State enum IDLE/SETUP/ACCESS.
  - Response struct {rdata, slverr, timeout}.
  - Command struct {addr, write, wdata, strb, prot}, width-parameterised via localparams.
- Sub-module sync_fifo:
  - Parameters WIDTH, DEPTH.
  - Ports: push, pop, full, empty, level.
  - First-word-fall-through head; instantiated once for the command queue.

Test Plan:
- Single write: addr 0x10, wdata 0xDEADBEEF, strb 0xF, PREADY tied 1 → PSELx at cycle +1, PENABLE at +2, rsp_valid at +3, slverr=0.
- Read with 2 wait states: PRDATA=0x12345678 at completion → rsp_rdata=0x12345678, rsp_valid at +5, PSTRB=0 throughout.
- Burst of 4 back-to-back writes (0x0..0xC):
  - Queue fills, o_cmd_ready low on a 5th offer.
  - PSELx stays high across all 4 transfers, PENABLE toggles 0/1, 4 rsp pulses 2 cycles apart.
- PSLVERR=1 on the second of two reads → second response slverr=1, timeout=0; the first is unaffected.
- TIMEOUT=16 with PREADY held 0 → abort after 16 ACCESS cycles: rsp timeout=1, slverr=1, PSELx=0, next queued command starts from IDLE.
- i_reset asserted in ACCESS with 2 commands queued → next edge all outputs reset, o_level=0, no rsp_valid ever issued for them.
